mem_slot_arbiter: RTL and testbench
===================================

# mem_slot_arbiter

Round-robin scheduler that shares the single read slot and single write slot of the phase-multiplexed 1-write/1-read memory among up to NREQ requesters. Owns the free-running 2-bit phase counter that the memory slots key off. Sits between the pipeline-side requesters (fetch, register read, debug) and the memory instance. The memory instance is driven from this block's phase_o, mem_read_o and mem_write_o outputs.

## Interface
- ELEMENTS_W, 7: memory address width.
- WIDTH, 32: data width.
- NREQ, 2: number of requesters; legal values are 2 to 4.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req_i  in  NREQ  per-requester read request; held until granted or withdrawn.
- rd_addr_i  in  NREQ*ELEMENTS_W  packed read addresses; requester n uses slice n.
- rd_gnt_o  out  NREQ  one-hot read grant, asserted in a phase 0 cycle.
- rd_rvalid_o  out  1  read data valid pulse, asserted in a phase 1 cycle.
- rd_id_o  out  2  index of the requester that owns rd_rdata_o.
- rd_rdata_o  out  WIDTH  read data.
- wr_req_i  in  NREQ  per-requester write request.
- wr_addr_i  in  NREQ*ELEMENTS_W  packed write addresses.
- wr_data_i  in  NREQ*WIDTH  packed write data.
- wr_gnt_o  out  NREQ  one-hot write grant, asserted in a phase 2 cycle; the write commits in that cycle.
- phase_o  out  2  current slot phase.
- mem_read_o  out  1  memory read strobe.
- mem_raddr_o  out  ELEMENTS_W  memory read address.
- mem_rdata_i  in  WIDTH  memory read data; synchronous, valid the cycle after mem_read_o.
- mem_write_o  out  1  memory write strobe.
- mem_waddr_o  out  ELEMENTS_W  memory write address.
- mem_wdata_o  out  WIDTH  memory write data.

## Operation
- Phase counter:
  - Registered; sequence is 0,1,2,3,0,…
  - Reset value is 0.
  - The first active edge after rst_n rises moves the phase to 1.
- Read slot, phase 0:
  - If any rd_req_i bit is set, pick winner r using the read round-robin pointer.
  - Drive rd_gnt_o[r]=1, mem_read_o=1, and mem_raddr_o = slice r of rd_addr_i. These are combinational from the phase and requests.
  - Register r as the pending read and set a pending flag.
- Read return, phase 1:
  - If the pending flag is set: rd_rvalid_o=1, rd_id_o=pending r, rd_rdata_o=mem_rdata_i. Then clear the flag.
  - rd_rdata_o passes mem_rdata_i through at all times; it is meaningful only while rd_rvalid_o=1.
- Write slot, phase 2:
  - Pick winner w using the write round-robin pointer.
  - Drive wr_gnt_o[w]=1, mem_write_o=1, and the address and data from slice w.
- Phase 3: idle. All grants, strobes and rd_rvalid_o are 0.
- Round-robin: separate read and write pointers (ptr = last granted index).
  - Search order is ptr+1, ptr+2, … modulo NREQ.
  - A pointer updates only when its slot issues a grant.
  - Reset value of each pointer is NREQ-1, so requester 0 has highest priority first.
- Withdrawal: a requester may drop its req before grant with no side effect. A req that is low in the slot cycle is not considered.
- Hazard: in the same frame, the phase-0 read precedes the phase-2 write, so the read returns the old data. A read in any later frame sees the new data. No forwarding.
- Unused index bits: indices of NREQ and above are never granted. rd_id_o is zero-extended.

## Timing
- Reset state, forced asynchronously while rst_n=0:
  - phase_o=0 and the pending flag is clear.
  - rd_gnt_o=0, wr_gnt_o=0, mem_read_o=0, mem_write_o=0, rd_rvalid_o=0, rd_id_o=0.
  - mem_raddr_o, mem_waddr_o and mem_wdata_o are 0.
- While rst_n=0, the grant and strobe outputs are held at 0 even though phase_o=0.
- Read latency: grant to rd_rvalid_o is exactly 1 cycle. Request to data is at most 4·NREQ cycles under full contention.
- Write latency: grant and commit happen in the same cycle. The worst-case wait is 4·NREQ cycles.
- Throughput: at most one read and one write per 4-cycle frame.
- Reset asserted mid-frame:
  - A pending read is discarded and no rd_rvalid_o is emitted.
  - The pointers return to NREQ-1.

## Test plan
- Single read after reset:
  - Stimulus: memory preloaded with [5]=0xA5A5_0001; rd_req_i=01 with addr 5, raised in a phase 3 cycle.
  - Expected: rd_gnt_o=01 at the next phase 0 with mem_raddr_o=5. One cycle later, rd_rvalid_o=1, rd_id_o=0, rd_rdata_o=0xA5A5_0001.
- Read contention, NREQ=2:
  - Stimulus: both rd_req_i bits held for 4 frames.
  - Expected: grants alternate 01,10,01,10. Exactly 4 rd_rvalid_o pulses with ids 0,1,0,1.
- Write/read ordering:
  - Stimulus: in one frame, req0 writes 0xDEAD_BEEF to [3] and req1 reads [3] (old value 0x0).
  - Expected: the read returns 0x0. The next-frame read of [3] returns 0xDEAD_BEEF.
- Write contention:
  - Stimulus: both wr_req_i bits held with addresses 10 and 11.
  - Expected: wr_gnt_o is 01 then 10 in consecutive phase 2 cycles, and memory [10] and [11] hold the written data.
- Reset mid-operation:
  - Stimulus: drop rst_n in the phase 0 cycle of a granted read.
  - Expected: all outputs go to 0 immediately and no rd_rvalid_o follows. After release, phase restarts at 0 and requester 0 wins the first contended grant.
- Withdrawal:
  - Stimulus: req1 raised in phase 1 and dropped in phase 3, with no other requests.
  - Expected: no grant, mem_read_o=0, and the read pointer is unchanged.

Source files
------------

// File: rtl/mem_slot_arbiter.sv
// Round-robin scheduler for the phase-multiplexed 1W/1R memory: phase 0 grants a read,
// phase 1 returns its data, phase 2 grants and commits a write, phase 3 is idle.
module mem_slot_arbiter #(
  parameter int ELEMENTS_W = 7,
  parameter int WIDTH      = 32,
  parameter int NREQ       = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            rd_req_i,
  input  logic [NREQ*ELEMENTS_W-1:0] rd_addr_i,
  output logic [NREQ-1:0]            rd_gnt_o,
  output logic                       rd_rvalid_o,
  output logic [1:0]                 rd_id_o,
  output logic [WIDTH-1:0]           rd_rdata_o,
  input  logic [NREQ-1:0]            wr_req_i,
  input  logic [NREQ*ELEMENTS_W-1:0] wr_addr_i,
  input  logic [NREQ*WIDTH-1:0]      wr_data_i,
  output logic [NREQ-1:0]            wr_gnt_o,
  output logic [1:0]                 phase_o,
  output logic                       mem_read_o,
  output logic [ELEMENTS_W-1:0]      mem_raddr_o,
  input  logic [WIDTH-1:0]           mem_rdata_i,
  output logic                       mem_write_o,
  output logic [ELEMENTS_W-1:0]      mem_waddr_o,
  output logic [WIDTH-1:0]           mem_wdata_o
);

  typedef enum logic [1:0] {
    PH_RD   = 2'd0,
    PH_RET  = 2'd1,
    PH_WR   = 2'd2,
    PH_IDLE = 2'd3
  } phase_t;

  localparam logic [1:0] PTR_RST = 2'(NREQ - 1);

  phase_t                r_phase;
  phase_t                w_phase_nxt;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_pend_id;
  logic                  r_pend;
  logic [1:0]            w_rd_win;
  logic [1:0]            w_wr_win;
  logic                  w_rd_slot;
  logic                  w_wr_slot;
  logic [3:0]            w_rd_onehot;
  logic [3:0]            w_wr_onehot;
  logic [ELEMENTS_W-1:0] w_raddr;
  logic [ELEMENTS_W-1:0] w_waddr;
  logic [WIDTH-1:0]      w_wdata;

  // Scan from farthest to nearest after ptr so the nearest requester overwrites the result.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    logic [3:0] req4;
    logic [2:0] idx;
    logic [1:0] win;
    req4 = 4'b0000;
    req4[NREQ-1:0] = req;
    win = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      idx = {1'b0, ptr} + 3'(i);
      idx = (idx >= 3'(NREQ)) ? (idx - 3'(NREQ)) : idx;
      win = req4[idx[1:0]] ? idx[1:0] : win;
    end
    return win;
  endfunction

  // Free-running slot phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_RD;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Phase sequencing.
  always_comb begin
    w_phase_nxt = PH_RD;
    case (r_phase)
      PH_RD:   w_phase_nxt = PH_RET;
      PH_RET:  w_phase_nxt = PH_WR;
      PH_WR:   w_phase_nxt = PH_IDLE;
      PH_IDLE: w_phase_nxt = PH_RD;
      default: w_phase_nxt = PH_RD;
    endcase
  end

  // Winner selection and slice muxing; rst_n gating keeps strobes low while phase is held at 0.
  always_comb begin
    w_rd_win    = rr_pick(rd_req_i, r_rd_ptr);
    w_wr_win    = rr_pick(wr_req_i, r_wr_ptr);
    w_rd_slot   = rst_n & (r_phase == PH_RD) & (|rd_req_i);
    w_wr_slot   = rst_n & (r_phase == PH_WR) & (|wr_req_i);
    w_rd_onehot = 4'b0001 << w_rd_win;
    w_wr_onehot = 4'b0001 << w_wr_win;
    w_raddr     = '0;
    w_waddr     = '0;
    w_wdata     = '0;
    for (int n = 0; n < NREQ; n++) begin
      w_raddr = (2'(n) == w_rd_win) ? rd_addr_i[n*ELEMENTS_W +: ELEMENTS_W] : w_raddr;
      w_waddr = (2'(n) == w_wr_win) ? wr_addr_i[n*ELEMENTS_W +: ELEMENTS_W] : w_waddr;
      w_wdata = (2'(n) == w_wr_win) ? wr_data_i[n*WIDTH +: WIDTH] : w_wdata;
    end
  end

  // Round-robin pointers and the single outstanding read tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= PTR_RST;
      r_wr_ptr  <= PTR_RST;
      r_pend    <= 1'b0;
      r_pend_id <= 2'd0;
    end else begin
      if (w_rd_slot) begin
        r_rd_ptr  <= w_rd_win;
        r_pend    <= 1'b1;
        r_pend_id <= w_rd_win;
      end else if (r_phase == PH_RET) begin
        r_pend    <= 1'b0;
      end
      if (w_wr_slot) begin
        r_wr_ptr <= w_wr_win;
      end
    end
  end

  assign phase_o     = r_phase;
  assign rd_gnt_o    = w_rd_slot ? w_rd_onehot[NREQ-1:0] : '0;
  assign mem_read_o  = w_rd_slot;
  assign mem_raddr_o = w_rd_slot ? w_raddr : '0;
  assign rd_rvalid_o = r_pend & (r_phase == PH_RET);
  assign rd_id_o     = r_pend_id;
  assign rd_rdata_o  = mem_rdata_i;
  assign wr_gnt_o    = w_wr_slot ? w_wr_onehot[NREQ-1:0] : '0;
  assign mem_write_o = w_wr_slot;
  assign mem_waddr_o = w_wr_slot ? w_waddr : '0;
  assign mem_wdata_o = w_wr_slot ? w_wdata : '0;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Scoreboard bench for mem_slot_arbiter with a behavioural synchronous memory attached.
module tb_mem_slot_arbiter;

  localparam int EW = 7;
  localparam int DW = 32;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    rd_req = '0;
  logic [NR*EW-1:0] rd_addr = '0;
  logic [NR-1:0]    rd_gnt;
  logic             rd_rvalid;
  logic [1:0]       rd_id;
  logic [DW-1:0]    rd_rdata;
  logic [NR-1:0]    wr_req = '0;
  logic [NR*EW-1:0] wr_addr = '0;
  logic [NR*DW-1:0] wr_data = '0;
  logic [NR-1:0]    wr_gnt;
  logic [1:0]       phase;
  logic             mem_read;
  logic [EW-1:0]    mem_raddr;
  logic [DW-1:0]    mem_rdata = '0;
  logic             mem_write;
  logic [EW-1:0]    mem_waddr;
  logic [DW-1:0]    mem_wdata;

  logic [DW-1:0] mem [0:127];

  typedef struct { logic [1:0] id; logic [DW-1:0] data; } rd_exp_t;
  typedef struct { logic [NR-1:0] gnt; logic [EW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_rv    = 0;
  int rv_base;

  mem_slot_arbiter #(.ELEMENTS_W(EW), .WIDTH(DW), .NREQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_rvalid_o(rd_rvalid), .rd_id_o(rd_id), .rd_rdata_o(rd_rdata),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .phase_o(phase), .mem_read_o(mem_read), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .mem_write_o(mem_write), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural memory: reads and writes never share a cycle, so blocking array updates are safe.
  always @(posedge clk) begin
    if (mem_write) mem[mem_waddr] = mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_raddr];
  end

  // Output monitor: pops the scoreboard on every read return and write grant.
  always @(negedge clk) begin
    if (rd_rvalid) begin
      n_rv++;
      if (rd_q.size() == 0) begin
        check_val("rvalid_unexpected", 64'd1, 64'd0);
      end else begin
        check_val("rd_phase", phase, 2'd1);
        check_val("rd_id", rd_id, rd_q[0].id);
        check_val("rd_data", rd_rdata, rd_q[0].data);
        void'(rd_q.pop_front());
      end
    end
    if (mem_write || wr_gnt != '0) begin
      if (wr_q.size() == 0) begin
        check_val("write_unexpected", 64'd1, 64'd0);
      end else begin
        check_val("wr_phase", phase, 2'd2);
        check_val("wr_gnt", wr_gnt, wr_q[0].gnt);
        check_val("wr_strobe", mem_write, 1'b1);
        check_val("wr_addr", mem_waddr, wr_q[0].addr);
        check_val("wr_data", mem_wdata, wr_q[0].data);
        void'(wr_q.pop_front());
      end
    end
  end

  task automatic wait_phase(input logic [1:0] p);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (phase != p && k < 8);
    check_val("phase_seq", phase, p);
  endtask

  task automatic push_rd(input logic [1:0] id, input logic [DW-1:0] data);
    rd_exp_t e;
    e.id = id;
    e.data = data;
    rd_q.push_back(e);
  endtask

  task automatic push_wr(input logic [NR-1:0] gnt, input logic [EW-1:0] addr, input logic [DW-1:0] data);
    wr_exp_t e;
    e.gnt = gnt;
    e.addr = addr;
    e.data = data;
    wr_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 32'h0000_0000;
    mem[5] = 32'hA5A5_0001;
    mem[7] = 32'h7777_0007;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_phase", phase, 2'd0);
    check_val("rst_rd_gnt", rd_gnt, 2'b00);
    check_val("rst_wr_gnt", wr_gnt, 2'b00);
    check_val("rst_strobes", {mem_read, mem_write, rd_rvalid}, 3'b000);
    check_val("rst_rd_id", rd_id, 2'd0);
    check_val("rst_addrs", {mem_raddr, mem_waddr, mem_wdata}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("phase_after_release", phase, 2'd1);

    // Single read after reset
    wait_phase(2'd3);
    rd_addr[0 +: EW] = 7'd5;
    rd_req = 2'b01;
    push_rd(2'd0, 32'hA5A5_0001);
    wait_phase(2'd0);
    check_val("t1_gnt", rd_gnt, 2'b01);
    check_val("t1_mem_read", mem_read, 1'b1);
    check_val("t1_raddr", mem_raddr, 7'd5);
    wait_phase(2'd1);
    rd_req = 2'b00;

    // Write contention
    wait_phase(2'd3);
    wr_addr[0 +: EW]  = 7'd10;
    wr_data[0 +: DW]  = 32'h1010_0A0A;
    wr_addr[EW +: EW] = 7'd11;
    wr_data[DW +: DW] = 32'h1111_0B0B;
    wr_req = 2'b11;
    push_wr(2'b01, 7'd10, 32'h1010_0A0A);
    push_wr(2'b10, 7'd11, 32'h1111_0B0B);
    wait_phase(2'd2);
    wait_phase(2'd3);
    wr_req = 2'b10;
    wait_phase(2'd2);
    wait_phase(2'd3);
    wr_req = 2'b00;
    check_val("mem10", mem[10], 32'h1010_0A0A);
    check_val("mem11", mem[11], 32'h1111_0B0B);

    // Write/read ordering within a frame
    rd_addr[EW +: EW] = 7'd3;
    rd_req = 2'b10;
    wr_addr[0 +: EW] = 7'd3;
    wr_data[0 +: DW] = 32'hDEAD_BEEF;
    wr_req = 2'b01;
    push_rd(2'd1, 32'h0000_0000);
    push_wr(2'b01, 7'd3, 32'hDEAD_BEEF);
    wait_phase(2'd0);
    check_val("t3_gnt", rd_gnt, 2'b10);
    check_val("t3_raddr", mem_raddr, 7'd3);
    wait_phase(2'd1);
    rd_req = 2'b00;
    wait_phase(2'd3);
    wr_req = 2'b00;
    rd_req = 2'b10;
    push_rd(2'd1, 32'hDEAD_BEEF);
    wait_phase(2'd0);
    check_val("t3_gnt2", rd_gnt, 2'b10);
    wait_phase(2'd1);
    rd_req = 2'b00;

    // Withdrawal: req1 raised in phase 1, dropped in phase 3
    rd_req = 2'b10;
    wait_phase(2'd3);
    rd_req = 2'b00;
    wait_phase(2'd0);
    check_val("wd_gnt", rd_gnt, 2'b00);
    check_val("wd_mem_read", mem_read, 1'b0);
    wait_phase(2'd3);
    rd_req = 2'b11;
    push_rd(2'd0, 32'hA5A5_0001);
    wait_phase(2'd0);
    check_val("wd_ptr_gnt", rd_gnt, 2'b01);
    wait_phase(2'd1);
    rd_req = 2'b00;

    // Reset in the phase 0 cycle of a granted read
    wait_phase(2'd3);
    rd_req = 2'b10;
    wait_phase(2'd0);
    check_val("mr_gnt_before", rd_gnt, 2'b10);
    rst_n = 1'b0;
    #1;
    check_val("mr_gnt", rd_gnt, 2'b00);
    check_val("mr_strobes", {mem_read, mem_write, rd_rvalid}, 3'b000);
    check_val("mr_phase", phase, 2'd0);
    check_val("mr_raddr", mem_raddr, 7'd0);
    rd_req = 2'b00;
    repeat (2) @(negedge clk);
    check_val("mr_rvalid_held", rd_rvalid, 1'b0);
    check_val("mr_phase_held", phase, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mr_phase_restart", phase, 2'd1);

    // Read contention for 4 frames: requester 0 wins first after reset
    wait_phase(2'd3);
    rd_addr[0 +: EW]  = 7'd5;
    rd_addr[EW +: EW] = 7'd7;
    rd_req = 2'b11;
    rv_base = n_rv;
    for (int f = 0; f < 4; f++) begin
      push_rd((f % 2 == 0) ? 2'd0 : 2'd1, (f % 2 == 0) ? 32'hA5A5_0001 : 32'h7777_0007);
    end
    for (int f = 0; f < 4; f++) begin
      wait_phase(2'd0);
      check_val("rc_gnt", rd_gnt, (f % 2 == 0) ? 2'b01 : 2'b10);
    end
    wait_phase(2'd1);
    rd_req = 2'b00;
    repeat (8) @(negedge clk);
    check_val("rc_rvalid_count", n_rv - rv_base, 4);
    check_val("rd_q_empty", rd_q.size(), 0);
    check_val("wr_q_empty", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
